// File: rtl/display_uart_tx.sv
// display_uart_tx: serialises bytes written to the display DDR register and drives DSR ready.
// Defining DISPLAY_TX_PARITY_EN adds an even-parity bit after the data bits (8E1 instead of 8N1).
module display_uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        LD_DDR,
    input  logic [15:0] ddr_out,
    output logic        LD_DSR_EXT,
    output logic [15:0] dsr_ext_out,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done,
    output logic        o_Overrun
);

    localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] DSR_READY = 16'h8000;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef DISPLAY_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        overrun_q, overrun_d;
    logic        ld_dsr_q, ld_dsr_d;
    logic [15:0] dsr_q, dsr_d;
    logic        tx_q, tx_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        baud_done;

    // Only the low byte is transmitted.
    logic        ddr_hi_unused;
    assign ddr_hi_unused = ^ddr_out[15:8];

    assign baud_done = (baud_q == BAUD_MAX);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        overrun_d = overrun_q;

        case (state_q)
            S_INIT: begin
                state_d = LD_DDR ? S_LOAD : S_IDLE;
            end
            S_IDLE: begin
                if (LD_DDR) state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = ddr_out[7:0];
                state_d = S_START;
                if (LD_DDR) overrun_d = 1'b1;
            end
            S_START: begin
                if (LD_DDR) overrun_d = 1'b1;
                if (baud_done) state_d = S_DATA;
                else           baud_d  = baud_q + 16'd1;
            end
            S_DATA: begin
                if (LD_DDR) overrun_d = 1'b1;
                if (baud_done) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef DISPLAY_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef DISPLAY_TX_PARITY_EN
            S_PARITY: begin
                if (LD_DDR) overrun_d = 1'b1;
                if (baud_done) state_d = S_STOP;
                else           baud_d  = baud_q + 16'd1;
            end
`endif
            S_STOP: begin
                if (LD_DDR) overrun_d = 1'b1;
                if (baud_done) state_d = S_DONE;
                else           baud_d  = baud_q + 16'd1;
            end
            S_DONE: begin
                state_d = LD_DDR ? S_LOAD : S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        ld_dsr_d = 1'b0;
        dsr_d    = '0;
        tx_d     = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;

        case (state_d)
            S_LOAD: begin
                ld_dsr_d = 1'b1;
            end
            S_START: begin
                tx_d     = 1'b0;
                active_d = 1'b1;
            end
            S_DATA: begin
                tx_d     = shift_d[bit_idx_d];
                active_d = 1'b1;
            end
`ifdef DISPLAY_TX_PARITY_EN
            S_PARITY: begin
                tx_d     = ^shift_d;
                active_d = 1'b1;
            end
`endif
            S_STOP: begin
                active_d = 1'b1;
            end
            S_DONE: begin
                done_d   = 1'b1;
                ld_dsr_d = 1'b1;
                dsr_d    = DSR_READY;
            end
            default: begin
            end
        endcase

        // INIT is held by reset, so its ready strobe is launched on the edge that leaves it.
        // A write landing in INIT goes straight to LOAD, whose clear supersedes the set.
        if (state_q == S_INIT && state_d == S_IDLE) begin
            ld_dsr_d = 1'b1;
            dsr_d    = DSR_READY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= S_INIT;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
            ld_dsr_q  <= 1'b0;
            dsr_q     <= '0;
            tx_q      <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
            ld_dsr_q  <= ld_dsr_d;
            dsr_q     <= dsr_d;
            tx_q      <= tx_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign LD_DSR_EXT  = ld_dsr_q;
    assign dsr_ext_out = dsr_q;
    assign o_Tx_Serial = tx_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_display_uart_tx.sv
// Scoreboard bench for display_uart_tx: a driver predicts frames and DSR strobes into queues,
// negedge monitors decode the line and strobes and compare against the queue heads.
`timescale 1ns/1ps
module tb_display_uart_tx;

    localparam int CPB = 4;
`ifdef DISPLAY_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    typedef struct {
        int          ld_cyc;
        logic [10:0] bits;
    } frame_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } dsr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic [15:0] ddr = '0;
    logic        ld_dsr;
    logic [15:0] dsr_val;
    logic        tx_serial, tx_active, tx_done, overrun;

    frame_t frame_q[$];
    dsr_t   dsr_q[$];
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    int     busy_until = 0;
    bit     ovr_model = 1'b0;

    display_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .LD_DDR     (ld),
        .ddr_out    (ddr),
        .LD_DSR_EXT (ld_dsr),
        .dsr_ext_out(dsr_val),
        .o_Tx_Serial(tx_serial),
        .o_Tx_Active(tx_active),
        .o_Tx_Done  (tx_done),
        .o_Overrun  (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference frame: start bit, data LSB first, optional even parity, stop bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i + 1] = d[i];
        if (NB == 11) b[9] = ^d;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // A write is accepted only when no frame is in flight (the DONE cycle counts as free).
    task automatic send(input logic [15:0] val);
        int c;
        c   = cyc;
        ld  = 1'b1;
        ddr = {8'($urandom), ~val[7:0]};
        if (c >= busy_until) begin
            frame_q.push_back('{c, frame_bits(val[7:0])});
            dsr_q.push_back('{c + 1, 16'h0000});
            dsr_q.push_back('{c + 2 + FRAME, 16'h8000});
            busy_until = c + 2 + FRAME;
        end else begin
            ovr_model = 1'b1;
        end
        tick();
        ld  = 1'b0;
        ddr = val;
        check("overrun_flag", overrun, ovr_model);
        tick();
        ddr = 16'($urandom);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick();
        frame_q.delete();
        dsr_q.delete();
        busy_until = 0;
        ovr_model  = 1'b0;
        repeat (n - 1) tick();
        rst = 1'b0;
        dsr_q.push_back('{cyc + 1, 16'h8000});
        repeat (3) tick();
    endtask

    // Monitor: reset state, DSR strobes, and a line decoder sampling mid-bit.
    bit     rst_prev = 1'b1;
    bit     in_frame = 1'b0;
    int     s_cyc = 0;
    int     off = 0;
    frame_t cur;
    dsr_t   d;

    always @(negedge clk) begin
        if (rst_prev) begin
            check("rst_tx_serial", tx_serial, 1'b1);
            check("rst_tx_active", tx_active, 1'b0);
            check("rst_tx_done", tx_done, 1'b0);
            check("rst_overrun", overrun, 1'b0);
            check("rst_ld_dsr", ld_dsr, 1'b0);
            check("rst_dsr_value", dsr_val, 16'h0000);
            in_frame = 1'b0;
        end else begin
            while (dsr_q.size() > 0 && dsr_q[0].cyc < cyc) begin
                check("dsr_strobe_missing", 32'd0, 32'd1);
                void'(dsr_q.pop_front());
            end
            if (ld_dsr) begin
                if (dsr_q.size() == 0) begin
                    check("dsr_strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    d = dsr_q.pop_front();
                    check("dsr_strobe_cycle", cyc, d.cyc);
                    check("dsr_strobe_value", dsr_val, d.val);
                end
            end else begin
                check("dsr_idle_value", dsr_val, 16'h0000);
            end

            if (!in_frame && tx_serial == 1'b0) begin
                if (frame_q.size() == 0) begin
                    check("start_bit_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = frame_q.pop_front();
                    check("start_cycle", cyc, cur.ld_cyc + 2);
                    in_frame = 1'b1;
                    s_cyc = cyc;
                end
            end
            if (in_frame) begin
                off = cyc - s_cyc;
                if (off < FRAME && (off % CPB) == CPB / 2)
                    check($sformatf("line_bit%0d", off / CPB), tx_serial, cur.bits[off / CPB]);
                check("tx_active", tx_active, off < FRAME);
                check("tx_done", tx_done, off == FRAME);
                if (off == FRAME) begin
                    check("line_at_done", tx_serial, 1'b1);
                    in_frame = 1'b0;
                end
            end else begin
                check("tx_active_idle", tx_active, 1'b0);
                check("tx_done_idle", tx_done, 1'b0);
            end
        end
        rst_prev = rst;
    end

    initial begin
        int c0;
        do_reset(4);

        // 'A' frame with a second write ten cycles in.
        c0 = cyc;
        send(16'h0041);
        wait_until(c0 + 10);
        send(16'h00FF);
        wait_until(busy_until + 3);
        check("overrun_sticky", overrun, ovr_model);

        do_reset(3);
        check("overrun_after_reset", overrun, ovr_model);

        // Write landing exactly on DONE, then the parity-interesting byte.
        send(16'h1234);
        wait_until(busy_until);
        send(16'hC355);
        wait_until(busy_until);
        send(16'h0007);
        wait_until(busy_until + 3);
        check("overrun_clear", overrun, ovr_model);

        // Randomised traffic: back-to-back on DONE, long gaps, and writes into busy frames.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       wait_until(busy_until);
                1:       repeat ($urandom_range(0, 60)) tick();
                default: repeat ($urandom_range(0, 5)) tick();
            endcase
            send(16'($urandom));
        end
        wait_until(busy_until + 3);

        // Reset during data bit 3 aborts the frame; the link then recovers.
        do_reset(2);
        c0 = cyc;
        send(16'h005A);
        wait_until(c0 + 2 + CPB + 3 * CPB + 1);
        do_reset(2);
        send(16'h00A5);
        wait_until(busy_until + 4);

        check("frames_pending", frame_q.size(), 32'd0);
        check("dsr_strobes_pending", dsr_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
